// File: rtl/pipe_reg_chain_if.sv
// Handshake and control bundle for pipe_reg_chain.
// master = producer/consumer side, slave = the chain itself.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InData;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;
    logic [DEPTH-1:0] Flush;
    logic             ClearAll;
    logic [OCC_W-1:0] Occupancy;

    modport master (
        output InValid, InData, OutReady, Flush, ClearAll,
        input  InReady, OutValid, OutData, Occupancy
    );

    modport slave (
        input  InValid, InData, OutReady, Flush, ClearAll,
        output InReady, OutValid, OutData, Occupancy
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic chain of DEPTH valid-tagged pipeline registers with per-stage flush,
// lockstep stall (COLLAPSE=0) or bubble-collapsing per-stage ready (COLLAPSE=1).
module pipe_reg_chain #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 3,
    parameter bit COLLAPSE = 1'b0,
    parameter bit CLRDATA  = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    pipe_reg_chain_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_flush;
    logic [DEPTH-1:0] w_prev_valid;
    logic [WIDTH-1:0] w_prev_data [DEPTH];
    logic [OCC_W-1:0] w_occ;

    // Ready is built from stage state and OutReady only, so Flush never reaches InReady.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        logic v_rdy;
        w_rdy = '0;
        v_rdy = ~r_valid[DEPTH-1] | bus.OutReady;
        if (COLLAPSE) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                v_rdy    = ~r_valid[i] | v_rdy;
                w_rdy[i] = v_rdy;
            end
        end else begin
            w_rdy = {DEPTH{v_rdy}};
        end
    end

    always_comb begin
        w_flush         = bus.Flush | {DEPTH{bus.ClearAll}};
        w_prev_valid    = '0;
        w_prev_valid[0] = bus.InValid;
        w_prev_data[0]  = bus.InData;
        for (int i = 1; i < DEPTH; i++) begin
            w_prev_valid[i] = r_valid[i-1];
            w_prev_data[i]  = r_data[i-1];
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_valid[i]);
        end
    end

    // NOTE: data regs are reset too, so OutData is a known zero out of reset.
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Flush wins over hold: a stalled stage is still squashed.
                if (w_flush[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_rdy[i]) begin
                    r_valid[i] <= w_prev_valid[i];
                end

                if (w_flush[i] && CLRDATA) begin
                    r_data[i] <= '0;
                end else if (w_rdy[i] && w_prev_valid[i]) begin
                    r_data[i] <= w_prev_data[i];
                end
            end
        end
    end

    assign bus.InReady   = w_rdy[0];
    assign bus.OutValid  = r_valid[DEPTH-1];
    assign bus.OutData   = r_data[DEPTH-1];
    assign bus.Occupancy = w_occ;
endmodule
